queue_ctrl: RTL and testbench
=============================

Name: queue_ctrl

Overview:
- Control/sequencing block for a register-based queue built from DEPTH instances of the team's 8-bit enabled storage register.
- Owns write/read pointers, occupancy count and valid/ready handshakes.
- Drives one-hot load enables into the register bank and the read-select for the external output mux; holds no data itself.
- Sits between the upstream producer and downstream consumer of the queue datapath.

Parameters:
- DEPTH, 8, number of storage registers controlled; legal range 2..64, any integer (need not be a power of 2).
- AF_THRESH, DEPTH-1, occupancy at or above which almost_full asserts; legal range 1..DEPTH.
- AW (localparam), clog2(DEPTH), pointer width.
- CW (localparam), clog2(DEPTH+1), count width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset: asserted at 0, released synchronously to clk by the system.
- flush  input  1  synchronous clear of queue state.
- in_valid  input  1  producer has a byte on the shared D bus of the register bank.
- in_ready  output  1  controller can accept a push this cycle.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer takes the head entry this cycle.
- reg_en  output  DEPTH  one-hot load enables, bit i drives EN of register i.
- rd_sel  output  AW  index of the head register, for the external output mux.
- count  output  CW  current occupancy, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- almost_full  output  1  count>=AF_THRESH.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: empty=1, full=0, almost_full=0, in_ready=1, out_valid=0, reg_en=0, rd_sel=0.
- Handshake qualifiers:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = !full & !flush. There is no push-through when full, even if a pop occurs in the same cycle.
  - out_valid = !empty & !flush.
- Write enables:
  - reg_en is combinational, = push ? (1<<wr_ptr) : 0.
  - The register selected captures D on the same rising edge the push is accepted. Zero write latency from the controller's side.
  - reg_en is never more than one-hot; it is all-zero during reset and flush.
- Read path:
  - rd_sel = rd_ptr, registered (comes straight from the pointer flop).
  - Head data is valid in the same cycle out_valid is high.
  - A newly pushed entry into an empty queue is visible the cycle after the push: 1-cycle fall-through latency.
- Pointer update on clock edge:
  - push: wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
  - pop: rd_ptr advances with the same wrap rule.
  - Wrap at DEPTH-1 is required for non-power-of-2 DEPTH. No reliance on natural overflow.
- Count:
  - push & !pop: +1.
  - pop & !push: -1.
  - both or neither: unchanged.
  - Push and pop in the same cycle is legal only when 0<count<DEPTH; the gating of in_ready/out_valid guarantees this.
- Status flags are combinational decodes of the registered count. No flag is itself a flop.
- Flush (synchronous, highest priority after reset):
  - Next state is pointers=0, count=0.
  - in_valid/out_ready are ignored in the flush cycle: no enable, no pop.
  - Stored register contents are not cleared; they are simply abandoned.
- Reset mid-operation: all state is lost immediately and asynchronously. Any reg_en in flight drops to 0 combinationally.
- Illegal-config guard: DEPTH<2 or AF_THRESH outside 1..DEPTH is caught by an elaboration-time check (generate-time error).

Decomposition:
- Shared package queue_pkg holds:
  - the default DEPTH constant;
  - the data width constant (8), shared with the storage register;
  - a clog2 function for AW/CW.
- One sub-module is natural: wrap_ptr (parameters DEPTH, AW; inputs clk, rst, clr, inc; output ptr). It is instanced twice, for the write and read pointers.
- Count/flag logic and enable decode stay in queue_ctrl.

Test Plan:
- Reset check, DEPTH=4: hold rst=0 -> count=0, empty=1, in_ready=1, out_valid=0, reg_en=4'b0000, rd_sel=0. Assert rst=0 mid-stream at count=3 -> same values immediately, without waiting for a clock edge.
- Fill, DEPTH=4, AF_THRESH=3, 4 pushes with out_ready=0:
  - reg_en sequence 0001, 0010, 0100, 1000.
  - almost_full rises when count=3.
  - After the 4th push: full=1, in_ready=0.
  - A 5th in_valid produces reg_en=0000 and count stays 4.
- Drain: from full, out_ready=1 for 4 cycles -> rd_sel 0,1,2,3. Then empty=1, out_valid=0; a further out_ready leaves count=0.
- Wrap with non-power-of-2 DEPTH=5:
  - Push 3, pop 3, then push 4.
  - reg_en bits 3,4,0,1 in order; wr_ptr wraps 4->0.
  - Then pop 4 -> rd_sel 3,4,0,1.
- Simultaneous push/pop at count=2, DEPTH=4: in_valid=out_ready=1 for 6 cycles -> count stays 2, one-hot reg_en rotates every cycle, rd_sel tracks two behind wr_ptr modulo 4.
- Flush at count=3 with in_valid=out_ready=1 in the same cycle: reg_en=0 that cycle. Next cycle count=0, rd_sel=0, empty=1. The next push drives reg_en=0001.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared constants and helpers for the register-based byte queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package queue_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DATA_W        = 8;

  // Ceiling log2, used to size pointers and the occupancy counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/queue_ctrl_wrap_ptr.sv
// Modulo-DEPTH pointer that wraps explicitly at DEPTH-1 (works for any DEPTH).
// Latency: pointer moves on the clock edge after inc is sampled high.
// Backpressure: none; the caller only raises inc on an accepted transfer.
module wrap_ptr #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] r_ptr;

  // Pointer register: clear has priority over increment; wrap is explicit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/queue_ctrl.sv
// Sequencer for a DEPTH-entry register queue: pointers, count, flags, load enables.
// Latency: write enable is combinational with the push; new head visible 1 cycle after push.
// Backpressure: in_ready drops when full or flushing; out_valid drops when empty or flushing.
module queue_ctrl
  import queue_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DEPTH-1:0]              reg_en,
  output logic [clog2(DEPTH)-1:0]       rd_sel,
  output logic [clog2(DEPTH + 1)-1:0]   count,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  // Reject configurations the pointer/flag logic cannot represent.
  generate
    if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_cfg
      $error("queue_ctrl: illegal DEPTH/AF_THRESH configuration");
    end
  endgenerate

  logic [AW-1:0] w_wr_ptr;
  logic [AW-1:0] w_rd_ptr;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] r_count;

  // Flags decode the registered count directly; none of them is a flop.
  assign empty       = (r_count == '0);
  assign full        = (r_count == CW'(DEPTH));
  assign almost_full = (r_count >= CW'(AF_THRESH));

  // No push-through when full, and nothing moves during a flush cycle.
  assign in_ready  = !full && !flush;
  assign out_valid = !empty && !flush;

  // rst gating keeps a load enable from escaping while reset is asserted.
  assign w_push = in_valid && in_ready && rst;
  assign w_pop  = out_valid && out_ready;

  assign rd_sel = w_rd_ptr;
  assign count  = r_count;

  // One-hot load enable for the register being written this cycle.
  always_comb begin
    reg_en = '0;
    if (w_push) begin
      reg_en = DEPTH'(1) << w_wr_ptr;
    end
  end

  // Occupancy: simultaneous push and pop cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CW'(1);
    end
  end

  wrap_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (w_push),
    .ptr (w_wr_ptr)
  );

  wrap_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (w_pop),
    .ptr (w_rd_ptr)
  );

endmodule

// File: tb/tb_queue_ctrl.sv
// Bench for queue_ctrl: a DEPTH=4 and a DEPTH=5 instance share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_queue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_empty, a_full, a_af;
  logic [3:0] a_reg_en;
  logic [1:0] a_rd_sel;
  logic [2:0] a_count;

  logic       b_in_ready, b_out_valid, b_empty, b_full, b_af;
  logic [4:0] b_reg_en;
  logic [2:0] b_rd_sel;
  logic [2:0] b_count;

  always #5 clk = ~clk;

  queue_ctrl #(.DEPTH(4), .AF_THRESH(3)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .reg_en(a_reg_en), .rd_sel(a_rd_sel), .count(a_count),
    .empty(a_empty), .full(a_full), .almost_full(a_af)
  );

  queue_ctrl #(.DEPTH(5)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .reg_en(b_reg_en), .rd_sel(b_rd_sel), .count(b_count),
    .empty(b_empty), .full(b_full), .almost_full(b_af)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: total pushes and pops since the last reset/flush.
  // Pointers are those totals modulo DEPTH, occupancy is their difference.
  int dep[2] = '{4, 5};
  int afth[2] = '{3, 4};
  int pu[2] = '{0, 0};
  int po[2] = '{0, 0};

  function automatic int m_cnt(input int i);
    return pu[i] - po[i];
  endfunction
  function automatic int m_in_ready(input int i);
    return (m_cnt(i) != dep[i] && !flush) ? 1 : 0;
  endfunction
  function automatic int m_out_valid(input int i);
    return (m_cnt(i) != 0 && !flush) ? 1 : 0;
  endfunction
  function automatic int m_reg_en(input int i);
    return (rst && in_valid && m_in_ready(i) == 1) ? (1 << (pu[i] % dep[i])) : 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      pu = '{0, 0};
      po = '{0, 0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        int p, q;
        p = (in_valid && m_in_ready(i) == 1) ? 1 : 0;
        q = (out_ready && m_out_valid(i) == 1) ? 1 : 0;
        pu[i] += p;
        po[i] += q;
      end
    end
  end

  int act_cnt[2], act_empty[2], act_full[2], act_af[2];
  int act_ir[2], act_ov[2], act_en[2], act_sel[2];
  always_comb begin
    act_cnt[0] = int'(a_count);     act_cnt[1] = int'(b_count);
    act_empty[0] = int'(a_empty);   act_empty[1] = int'(b_empty);
    act_full[0] = int'(a_full);     act_full[1] = int'(b_full);
    act_af[0] = int'(a_af);         act_af[1] = int'(b_af);
    act_ir[0] = int'(a_in_ready);   act_ir[1] = int'(b_in_ready);
    act_ov[0] = int'(a_out_valid);  act_ov[1] = int'(b_out_valid);
    act_en[0] = int'(a_reg_en);     act_en[1] = int'(b_reg_en);
    act_sel[0] = int'(a_rd_sel);    act_sel[1] = int'(b_rd_sel);
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d.count", i), act_cnt[i], m_cnt(i));
      chk($sformatf("m%0d.empty", i), act_empty[i], (m_cnt(i) == 0) ? 1 : 0);
      chk($sformatf("m%0d.full", i), act_full[i], (m_cnt(i) == dep[i]) ? 1 : 0);
      chk($sformatf("m%0d.almost_full", i), act_af[i], (m_cnt(i) >= afth[i]) ? 1 : 0);
      chk($sformatf("m%0d.in_ready", i), act_ir[i], m_in_ready(i));
      chk($sformatf("m%0d.out_valid", i), act_ov[i], m_out_valid(i));
      chk($sformatf("m%0d.reg_en", i), act_en[i], m_reg_en(i));
      chk($sformatf("m%0d.rd_sel", i), act_sel[i], po[i] % dep[i]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held: literal reset values.
    repeat (3) cyc();
    chk("rst.count", a_count, 0);
    chk("rst.empty", a_empty, 1);
    chk("rst.in_ready", a_in_ready, 1);
    chk("rst.out_valid", a_out_valid, 0);
    chk("rst.reg_en", a_reg_en, 0);
    chk("rst.rd_sel", a_rd_sel, 0);
    rst = 1'b1;

    // Fill DEPTH=4.
    for (int k = 0; k < 4; k++) begin
      cyc();
      in_valid = 1'b1;
      #1;
      chk("fill.reg_en", a_reg_en, 1 << k);
      chk("fill.almost_full", a_af, (k >= 3) ? 1 : 0);
    end
    cyc();
    #1;
    chk("full.full", a_full, 1);
    chk("full.in_ready", a_in_ready, 0);
    chk("full.reg_en", a_reg_en, 0);
    chk("full.count", a_count, 4);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("full.count_hold", a_count, 4);

    // Drain DEPTH=4.
    for (int k = 0; k < 4; k++) begin
      cyc();
      out_ready = 1'b1;
      #1;
      chk("drain.rd_sel", a_rd_sel, k);
    end
    cyc();
    #1;
    chk("drain.empty", a_empty, 1);
    chk("drain.out_valid", a_out_valid, 0);
    cyc();
    out_ready = 1'b0;
    #1;
    chk("drain.count_hold", a_count, 0);

    // Wrap on DEPTH=5: push 3, pop 3, push 4, pop 4.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; #1;
      chk("wrap.push_a", b_reg_en, 1 << k);
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b1; #1;
      chk("wrap.pop_a", b_rd_sel, k);
      cyc();
    end
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; #1;
      chk("wrap.push_b", b_reg_en, 1 << ((3 + k) % 5));
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b1; #1;
      chk("wrap.pop_b", b_rd_sel, (3 + k) % 5);
      cyc();
    end
    out_ready = 1'b0;
    #1;
    chk("wrap.empty", b_empty, 1);

    // Simultaneous push/pop at count=2 on DEPTH=4.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; #1;
      cyc();
    end
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; out_ready = 1'b1; #1;
      chk("both.count", a_count, 2);
      chk("both.reg_en", a_reg_en, 1 << ((2 + k) % 4));
      chk("both.rd_sel", a_rd_sel, k % 4);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Flush at count=3 with both handshakes requested.
    in_valid = 1'b1; #1;
    cyc();
    in_valid = 1'b0; #1;
    chk("flush.pre_count", a_count, 3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; #1;
    chk("flush.reg_en", a_reg_en, 0);
    chk("flush.out_valid", a_out_valid, 0);
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("flush.count", a_count, 0);
    chk("flush.rd_sel", a_rd_sel, 0);
    chk("flush.empty", a_empty, 1);
    in_valid = 1'b1; #1;
    chk("flush.next_en", a_reg_en, 1);
    cyc();

    // Asynchronous reset mid-stream at count=3, push still requested.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; #1;
      cyc();
    end
    #2;
    chk("arst.pre_count", a_count, 3);
    rst = 1'b0;
    #1;
    chk("arst.count", a_count, 0);
    chk("arst.reg_en", a_reg_en, 0);
    chk("arst.empty", a_empty, 1);
    chk("arst.in_ready", a_in_ready, 1);
    chk("arst.out_valid", a_out_valid, 0);
    chk("arst.rd_sel", a_rd_sel, 0);
    in_valid = 1'b0;
    cyc();
    rst = 1'b1;

    // Random traffic, alternating push-heavy and pop-heavy phases.
    for (int n = 0; n < 3000; n++) begin
      bit fill_phase;
      cyc();
      fill_phase = ((n / 150) % 2) == 0;
      in_valid  = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      out_ready = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 79) == 0);
      rst       = ($urandom_range(0, 599) != 0);
    end
    cyc();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
